// File: rtl/sensor_msg_pkg.sv
// Shared constants, FSM state type and helpers for the IR sensor message formatter.
package sensor_msg_pkg;

  localparam logic [7:0] ASCII_I    = 8'h49;
  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam int MSG_LEN_BASE = 6;
  localparam int MSG_LEN_SEQ  = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } msg_state_e;

  // 0x37 + 10 lands on 'A', so A-F come out uppercase.
  function automatic logic [7:0] hexChar(input logic [3:0] nib);
    hexChar = (nib < 4'd10) ? (ASCII_ZERO + {4'd0, nib}) : (8'h37 + {4'd0, nib});
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus stability counter producing the debounced sensor level.
module sensor_debounce
  import sensor_msg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level
);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // The flip happens on the increment that would bring the count to DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sensor_msg_fmt.sv
// Streams "IR=<level>\r\n" into the UART one byte per busy handshake.
// Define SENSOR_MSG_SEQ_EN to append " <HH>" carrying an 8-bit message sequence number.
module sensor_msg_fmt
  import sensor_msg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_in,
  input  logic       sample_en,
  input  logic       tx_busy,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  output logic       msg_busy,
  output logic       dropped,
  output logic       sensor_level
);

`ifdef SENSOR_MSG_SEQ_EN
  localparam int MSG_LEN = MSG_LEN_SEQ;
`else
  localparam int MSG_LEN = MSG_LEN_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  msg_state_e state_q;
  logic [3:0] idx_q;
  logic       digit_q;
  logic [7:0] txByte_q;
  logic       txStart_q;
  logic       msgBusy_q;
  logic       dropped_q;
  logic [7:0] frameByte;
`ifdef SENSOR_MSG_SEQ_EN
  logic [7:0] seq_q;
`endif

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .in   (sensor_in),
    .level(sensor_level)
  );

  always_comb begin
    frameByte = 8'h00;
    case (idx_q)
      4'd0: frameByte = ASCII_I;
      4'd1: frameByte = ASCII_R;
      4'd2: frameByte = ASCII_EQ;
      4'd3: frameByte = ASCII_ZERO | {7'd0, digit_q};
`ifdef SENSOR_MSG_SEQ_EN
      4'd4: frameByte = ASCII_SP;
      4'd5: frameByte = hexChar(seq_q[7:4]);
      4'd6: frameByte = hexChar(seq_q[3:0]);
      4'd7: frameByte = ASCII_CR;
      4'd8: frameByte = ASCII_LF;
`else
      4'd4: frameByte = ASCII_CR;
      4'd5: frameByte = ASCII_LF;
`endif
      default: frameByte = 8'h00;
    endcase
  end

  // The digit is captured at accept so later sensor edges cannot corrupt a frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      digit_q   <= 1'b0;
      txByte_q  <= 8'h00;
      txStart_q <= 1'b0;
      msgBusy_q <= 1'b0;
      dropped_q <= 1'b0;
`ifdef SENSOR_MSG_SEQ_EN
      seq_q     <= 8'h00;
`endif
    end else begin
      txStart_q <= 1'b0;
      dropped_q <= sample_en && msgBusy_q;
      case (state_q)
        IDLE: begin
          if (sample_en) begin
            digit_q   <= sensor_level;
            idx_q     <= 4'd0;
            msgBusy_q <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          txByte_q  <= frameByte;
          txStart_q <= 1'b1;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              msgBusy_q <= 1'b0;
              state_q   <= IDLE;
`ifdef SENSOR_MSG_SEQ_EN
              seq_q     <= seq_q + 8'd1;
`endif
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_byte  = txByte_q;
  assign tx_start = txStart_q;
  assign msg_busy = msgBusy_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_sensor_msg_fmt.sv
// Self-checking bench for sensor_msg_fmt: timing-rule reference model, UART responder, randomized traffic.
module tb_sensor_msg_fmt;

  localparam int DEB = 16;
`ifdef SENSOR_MSG_SEQ_EN
  localparam int MSG_LEN = 9;
  localparam logic [8*9-1:0] FRAME_IR1 = {8'h49, 8'h52, 8'h3D, 8'h31, 8'h20, 8'h30, 8'h30, 8'h0D, 8'h0A};
`else
  localparam int MSG_LEN = 6;
  localparam logic [8*6-1:0] FRAME_IR1 = {8'h49, 8'h52, 8'h3D, 8'h31, 8'h0D, 8'h0A};
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_in = 1'b0;
  logic       sample_en = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       msg_busy;
  logic       dropped;
  logic       sensor_level;

  sensor_msg_fmt #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_in   (sensor_in),
    .sample_en   (sample_en),
    .tx_busy     (tx_busy),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .msg_busy    (msg_busy),
    .dropped     (dropped),
    .sensor_level(sensor_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Reference model: expected outputs for the cycle after the next rising edge.
  logic       expLevel, expStart, expMsgBusy, expDropped;
  logic [7:0] expByte;
  logic       hist [0:DEB+1];
  logic [7:0] frame [0:MSG_LEN-1];
  int         pos, seqModel;
  bit         loadDue, awaitRise, awaitFall;
  string      hexDigits = "0123456789ABCDEF";

  int  uartDelay = -1, uartBusyLeft = 0, nextDelay = 0, busyLen = 10;
  bit  idleNoise = 0;
  logic [7:0] seenBytes [$];
  int  startCount = 0, dropCount = 0;
  logic sens = 1'b0;

  task automatic checkOne(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%02h, expected 0x%02h", name, cycle, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cycle, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("tx_start", {7'd0, tx_start}, {7'd0, expStart});
    checkOne("tx_byte", tx_byte, expByte);
    checkOne("msg_busy", {7'd0, msg_busy}, {7'd0, expMsgBusy});
    checkOne("dropped", {7'd0, dropped}, {7'd0, expDropped});
    checkOne("sensor_level", {7'd0, sensor_level}, {7'd0, expLevel});
  endtask

  task automatic modelReset();
    expLevel = 0; expStart = 0; expMsgBusy = 0; expDropped = 0; expByte = 8'h00;
    for (int i = 0; i <= DEB + 1; i++) hist[i] = 1'b0;
    pos = 0; seqModel = 0; loadDue = 0; awaitRise = 0; awaitFall = 0;
  endtask

  task automatic buildFrame(input logic d);
    frame[0] = 8'h49;
    frame[1] = 8'h52;
    frame[2] = 8'h3D;
    frame[3] = d ? 8'h31 : 8'h30;
`ifdef SENSOR_MSG_SEQ_EN
    frame[4] = 8'h20;
    frame[5] = hexDigits[seqModel / 16];
    frame[6] = hexDigits[seqModel % 16];
    frame[7] = 8'h0D;
    frame[8] = 8'h0A;
`else
    frame[4] = 8'h0D;
    frame[5] = 8'h0A;
`endif
  endtask

  // Message timing follows the accept->start(+2) and busy-fall->start(+2) rules; the level
  // flips once the synchronised input has disagreed with it for DEB consecutive edges.
  task automatic modelStep(input logic r, input logic s, input logic se, input logic b);
    bit allDiffer;
    if (r) begin
      modelReset();
    end else begin
      expDropped = se && expMsgBusy;
      expStart = 0;
      if (!expMsgBusy) begin
        if (se) begin
          buildFrame(expLevel);
          pos = 0; expMsgBusy = 1; loadDue = 1;
        end
      end else if (loadDue) begin
        expStart = 1; expByte = frame[pos]; loadDue = 0; awaitRise = 1;
      end else if (awaitRise) begin
        if (b) begin awaitRise = 0; awaitFall = 1; end
      end else if (awaitFall && !b) begin
        awaitFall = 0;
        if (pos == MSG_LEN - 1) begin
          expMsgBusy = 0;
          seqModel = (seqModel + 1) % 256;
        end else begin
          pos++;
          loadDue = 1;
        end
      end
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = s;
      allDiffer = 1;
      for (int i = 2; i <= DEB + 1; i++) if (hist[i] == expLevel) allDiffer = 0;
      if (allDiffer) expLevel = ~expLevel;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic se);
    rst = r;
    sensor_in = s;
    sample_en = se;
    if (tx_start === 1'b1) uartDelay = nextDelay;
    if (uartDelay == 0) begin
      uartBusyLeft = busyLen;
      uartDelay = -1;
    end else if (uartDelay > 0) begin
      uartDelay--;
    end
    if (uartBusyLeft > 0) begin
      tx_busy = 1'b1;
      uartBusyLeft--;
    end else begin
      tx_busy = (idleNoise && msg_busy === 1'b0) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic se);
    @(negedge clk);
    cycle++;
    checkOutput();
    if (tx_start === 1'b1) begin
      seenBytes.push_back(tx_byte);
      startCount++;
    end
    if (dropped === 1'b1) dropCount++;
    applyStimulus(r, s, se);
    modelStep(r, s, se, tx_busy);
  endtask

  task automatic waitMsgDone(input int budget);
    int n = 0;
    tick(1'b0, sens, 1'b0);
    while (msg_busy === 1'b1 && n < budget) begin
      tick(1'b0, sens, 1'b0);
      n++;
    end
    checkOne("msg_done_timeout", {7'd0, msg_busy}, 8'h00);
  endtask

  task automatic waitBytes(input int count, input int budget);
    int n = 0;
    while (seenBytes.size() < count && n < budget) begin
      tick(1'b0, sens, 1'b0);
      n++;
    end
    checkInt("byte_wait_timeout", seenBytes.size(), count);
  endtask

  initial begin
    logic [8*MSG_LEN-1:0] ref1;
    int starts0;
    modelReset();
    ref1 = FRAME_IR1;

    repeat (3) tick(1'b1, 1'b0, 1'b0);
    checkOne("reset_tx_byte", tx_byte, 8'h00);
    checkOne("reset_msg_busy", {7'd0, msg_busy}, 8'h00);

    // Steady high sensor, then one full frame.
    sens = 1'b1;
    repeat (40) tick(1'b0, sens, 1'b0);
    checkOne("level_after_hold", {7'd0, sensor_level}, 8'h01);
    seenBytes.delete(); startCount = 0;
    tick(1'b0, sens, 1'b1);
    waitMsgDone(400);
    checkInt("frame1_len", seenBytes.size(), MSG_LEN);
    for (int i = 0; i < MSG_LEN && i < seenBytes.size(); i++)
      checkOne("frame1_byte", seenBytes[i], ref1[8*(MSG_LEN-1-i) +: 8]);
    checkInt("frame1_starts", startCount, MSG_LEN);

    // Return low, then a glitch one cycle too short to register.
    sens = 1'b0;
    repeat (40) tick(1'b0, sens, 1'b0);
    repeat (DEB - 1) tick(1'b0, 1'b1, 1'b0);
    repeat (25) tick(1'b0, sens, 1'b0);
    checkOne("level_after_glitch", {7'd0, sensor_level}, 8'h00);
    seenBytes.delete();
    tick(1'b0, sens, 1'b1);
    waitMsgDone(400);
    if (seenBytes.size() > 3) checkOne("glitch_digit", seenBytes[3], 8'h30);
    else checkInt("glitch_frame_len", seenBytes.size(), MSG_LEN);

    // Request arriving mid-frame is dropped, frame length unchanged.
    seenBytes.delete(); dropCount = 0;
    tick(1'b0, sens, 1'b1);
    waitBytes(3, 200);
    tick(1'b0, sens, 1'b1);
    waitMsgDone(400);
    checkInt("drop_pulses", dropCount, 1);
    checkInt("drop_frame_len", seenBytes.size(), MSG_LEN);

    // Reset while the second byte is shifting out.
    seenBytes.delete();
    tick(1'b0, sens, 1'b1);
    waitBytes(2, 200);
    repeat (3) tick(1'b0, sens, 1'b0);
    tick(1'b1, sens, 1'b0);
    tick(1'b0, sens, 1'b0);
    checkOne("abort_msg_busy", {7'd0, msg_busy}, 8'h00);
    checkOne("abort_tx_byte", tx_byte, 8'h00);
    starts0 = startCount;
    repeat (30) tick(1'b0, sens, 1'b0);
    checkInt("abort_no_start", startCount, starts0);
    seenBytes.delete();
    tick(1'b0, sens, 1'b1);
    waitMsgDone(400);
    if (seenBytes.size() > 0) checkOne("restart_first_byte", seenBytes[0], 8'h49);
    else checkInt("restart_frame_len", seenBytes.size(), MSG_LEN);

    // UART slow to raise busy: no second start while waiting.
    seenBytes.delete(); nextDelay = 50;
    tick(1'b0, sens, 1'b1);
    waitBytes(1, 50);
    nextDelay = 0;
    repeat (45) tick(1'b0, sens, 1'b0);
    checkInt("stall_single_start", seenBytes.size(), 1);
    waitMsgDone(600);
    checkInt("stall_frame_len", seenBytes.size(), MSG_LEN);

    // Randomized traffic.
    idleNoise = 1;
    for (int k = 0; k < 4000; k++) begin
      logic r, se;
      if ($urandom_range(0, 29) == 0) sens = ~sens;
      r = ($urandom_range(0, 499) == 0);
      se = ($urandom_range(0, 39) == 0);
      nextDelay = $urandom_range(0, 3);
      busyLen = $urandom_range(1, 12);
      tick(r, sens, se);
    end
    idleNoise = 0;

`ifdef SENSOR_MSG_SEQ_EN
    // Sequence number wraps after 256 completed messages.
    nextDelay = 0; busyLen = 1; sens = 1'b0;
    repeat (2) tick(1'b1, sens, 1'b0);
    repeat (30) tick(1'b0, sens, 1'b0);
    for (int k = 0; k <= 256; k++) begin
      seenBytes.delete();
      tick(1'b0, sens, 1'b1);
      waitMsgDone(200);
      checkInt("seq_frame_len", seenBytes.size(), 9);
      if (seenBytes.size() == 9 && (k == 0 || k == 255 || k == 256)) begin
        checkOne("seq_hi", seenBytes[5], (k == 255) ? 8'h46 : 8'h30);
        checkOne("seq_lo", seenBytes[6], (k == 255) ? 8'h46 : 8'h30);
      end
      tick(1'b0, sens, 1'b0);
    end
`endif

    repeat (5) tick(1'b0, sens, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_msg_fmt.md
# sensor_msg_fmt

Formats the debounced IR sensor level into a short ASCII line and streams it byte-by-byte into the 8N1 UART transmitter. It sits directly upstream of the UART, in the same baud-clock domain. It replaces the single raw sensor byte with a human-readable frame such as "IR=1\r\n", pacing each byte on the transmitter's busy handshake.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable `clk` cycles required before the debounced level changes.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; not overridden.

- clk  in  1  baud-domain clock (9600 toggle clock).
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- sensor_in  in  1  raw IR sensor pin, asynchronous.
- sample_en  in  1  one-cycle request to emit one message.
- tx_busy  in  1  UART busy; high while a byte is shifting out.
- tx_byte  out  8  byte presented to the UART. Stable from `tx_start` until `tx_busy` falls.
- tx_start  out  1  one-cycle send strobe to the UART.
- msg_busy  out  1  high from message accept until the last byte completes.
- dropped  out  1  one-cycle pulse when `sample_en` arrives while `msg_busy` is high.
- sensor_level  out  1  debounced sensor level.

## Operation
- Input path: `sensor_in` goes through a 2-flop synchronizer, then the debouncer.
- Debouncer: counter clears whenever the synchronized input equals `sensor_level`. Otherwise it increments; on reaching DEBOUNCE_CYCLES, `sensor_level` flips and the counter clears.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - IDLE: on `sample_en`, latch `sensor_level` into the message digit, set index=0 and `msg_busy`=1, go to LOAD.
  - LOAD: drive `tx_byte` = frame[index], pulse `tx_start`, go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy`=1, go to WAIT_DONE.
  - WAIT_DONE: when `tx_busy`=0, either:
    - if index = last: clear `msg_busy` and go to IDLE;
    - otherwise: index+1 and go to LOAD.
- Frame without sequence: 'I'(0x49), 'R'(0x52), '='(0x3D), '0'/'1'(0x30/0x31), CR(0x0D), LF(0x0A). Length 6.
- Digit is the level latched at accept. Later sensor changes do not alter an in-flight frame.
- `sample_en` while `msg_busy`=1 is discarded and `dropped` pulses the next cycle. No queuing.
- `sample_en` in the same cycle the last byte completes is dropped, because `msg_busy` is still 1 that cycle.
- `tx_busy` already high in IDLE is ignored. LOAD does not check `tx_busy`; the UART owns the busy contract.
- Reset mid-message: FSM returns to IDLE immediately. The partial frame is abandoned and no further `tx_start` is issued.
- Reset values: `tx_byte`=0x00, `tx_start`=0, `msg_busy`=0, `dropped`=0, `sensor_level`=0. The synchronizer, debounce counter, index and sequence counter are also 0.

## Timing
- `sample_en` at cycle N (IDLE) → `msg_busy`=1 at N+1 and `tx_start` at N+2, with `tx_byte`=first byte.
- `tx_busy` falling observed at cycle M → next `tx_start` at M+2 (through LOAD).
- Raw input change → `sensor_level` update after 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1.
- `tx_start` is never high for two consecutive cycles.

## Configuration
- Macro: SENSOR_MSG_SEQ_EN.
- When defined:
  - An 8-bit sequence counter appends ' '(0x20) plus two uppercase hex digits before CR/LF, giving "IR=1 2A\r\n" (length 9).
  - The counter increments on each completed message and wraps 0xFF→0x00.
  - A reset-aborted message does not increment it.
- When undefined: no counter, 6-byte frame, identical timing otherwise.

## Structure
- Package sensor_msg_pkg holds:
  - the ASCII constants (I, R, =, space, CR, LF, '0');
  - the FSM state enum;
  - MSG_LEN_BASE=6 and MSG_LEN_SEQ=9;
  - a nibble-to-uppercase-hex function.
- Sub-module sensor_debounce, parameterised by DEBOUNCE_CYCLES, contains the synchronizer and debounce counter. Its ports are clk, rst, in, level.

## Test plan
- Sensor held 1 for 40 cycles, then `sample_en`, with a UART model (busy 10 cycles after each start) → bytes 0x49, 0x52, 0x3D, 0x31, 0x0D, 0x0A in order, six `tx_start` pulses.
- Sensor glitch high for DEBOUNCE_CYCLES-1 cycles → `sensor_level` stays 0, and a subsequent frame carries 0x30.
- `sample_en` during byte 3 → `dropped` pulses once and exactly six bytes are sent.
- `rst` asserted in WAIT_DONE of byte 2 → outputs at reset values the next cycle and no further `tx_start`. A new `sample_en` then restarts at 0x49.
- With SENSOR_MSG_SEQ_EN, 257 back-to-back messages → sequence digits 0x30,0x30 ... 0x46,0x46, then wrap to 0x30,0x30. Each frame is 9 bytes.
- `tx_busy` held low for 50 cycles after `tx_start` → FSM stays in WAIT_BUSY with no second `tx_start`. When busy is then pulsed, the frame resumes.
